// File: rtl/pe_dot_accum_if.sv
// Handshake and data bus for pe_dot_accum: weight load, job start, activation
// stream and result channel, with master (driver) and slave (PE) views.
interface pe_dot_accum_if #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 8
);
   logic                      w_load;
   logic [LANES*DATA_W-1:0]   w_in;
   logic                      start;
   logic [CNT_W-1:0]          len;
   logic [ACC_W-1:0]          psum_in;
   logic                      act_valid;
   logic [LANES*DATA_W-1:0]   act_in;
   logic                      act_ready;
   logic                      out_valid;
   logic                      out_ready;
   logic [ACC_W-1:0]          out_psum;
   logic                      sat;

   modport master (
      output w_load, w_in, start, len, psum_in, act_valid, act_in, out_ready,
      input  act_ready, out_valid, out_psum, sat
   );

   modport slave (
      input  w_load, w_in, start, len, psum_in, act_valid, act_in, out_ready,
      output act_ready, out_valid, out_psum, sat
   );
endinterface

// File: rtl/pe_dot_accum.sv
// Weight-stationary dot-product PE: one LANES-wide beat per cycle is reduced to a
// single product sum, registered, then added into a saturating accumulator.
module pe_dot_accum #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int ACC_W  = 32,
   parameter int SEM    = 1,
   parameter int CNT_W  = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   pe_dot_accum_if.slave bus
);
   localparam int P_W = 2*DATA_W;
   localparam int S_W = P_W + $clog2(LANES);

   typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

   state_t                   r_state, w_state_nxt;
   logic [LANES*DATA_W-1:0]  r_w;
   logic signed [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_sat;
   logic signed [S_W-1:0]    r_prod_p1;
   logic                     r_vld_p1;

   logic                     w_accept;
   logic signed [S_W-1:0]    w_lane_sum;
   logic signed [P_W-1:0]    w_prod;
   logic [ACC_W:0]           w_add;

   // Sign-magnitude multiply keeps magnitudes unsigned and applies the XOR sign
   // afterwards; a zero magnitude negates to zero, so negative zero vanishes.
   function automatic logic signed [P_W-1:0] lane_mul(input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
      logic [P_W-3:0]        mag;
      logic signed [P_W-1:0] res;
      if (SEM != 0) begin
         mag = a[DATA_W-2:0] * b[DATA_W-2:0];
         res = {2'b00, mag};
         if (a[DATA_W-1] ^ b[DATA_W-1])
            res = -res;
      end else begin
         res = $signed(a) * $signed(b);
      end
      return res;
   endfunction

   // Returns {overflow, clamped sum}.
   function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] acc,
                                              input logic signed [S_W-1:0]   p);
      logic signed [ACC_W:0] s;
      logic [ACC_W:0]        res;
      s = {acc[ACC_W-1], acc} + {{(ACC_W+1-S_W){p[S_W-1]}}, p};
      if (s[ACC_W] != s[ACC_W-1])
         res = s[ACC_W] ? {1'b1, 1'b1, {(ACC_W-1){1'b0}}}
                        : {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      else
         res = {1'b0, s[ACC_W-1:0]};
      return res;
   endfunction

   assign w_accept = (r_state == ACCUM) && bus.act_valid;
   assign w_add    = sat_add(r_acc, r_prod_p1);

   always_comb begin
      w_lane_sum = '0;
      w_prod     = '0;
      for (int i = 0; i < LANES; i++) begin
         w_prod     = lane_mul(r_w[i*DATA_W +: DATA_W], bus.act_in[i*DATA_W +: DATA_W]);
         w_lane_sum = w_lane_sum + S_W'(w_prod);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_nxt = (bus.len == '0) ? FLUSH : ACCUM;
         ACCUM:   if (w_accept && (r_cnt == CNT_W'(1))) w_state_nxt = FLUSH;
         FLUSH:   w_state_nxt = DONE;
         DONE:    if (bus.out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Stage p1: reduced beat product; consumed by the accumulator on the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w       <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_sat     <= 1'b0;
         r_prod_p1 <= '0;
         r_vld_p1  <= 1'b0;
      end else begin
         r_vld_p1 <= w_accept;
         if (w_accept) begin
            r_prod_p1 <= w_lane_sum;
            r_cnt     <= r_cnt - CNT_W'(1);
         end
         if ((r_state == IDLE) && bus.w_load)
            r_w <= bus.w_in;
         if ((r_state == IDLE) && bus.start) begin
            r_acc <= bus.psum_in;
            r_cnt <= bus.len;
            r_sat <= 1'b0;
         end else if (r_vld_p1) begin
            r_acc <= w_add[ACC_W-1:0];
            if (w_add[ACC_W])
               r_sat <= 1'b1;
         end
      end
   end

   assign bus.act_ready = (r_state == ACCUM);
   assign bus.out_valid = (r_state == DONE);
   assign bus.out_psum  = r_acc;
   assign bus.sat       = r_sat;
endmodule

// File: doc/pe_dot_accum.md
# pe_dot_accum

Parametrised processing element: multiplies a LANES-wide activation vector by a stationary weight vector, reduces the products and accumulates the dot product over a programmable number of beats, starting from an injected partial sum. Inputs are sign-magnitude or two's complement, selected by parameter. The accumulator saturates, and the result leaves through a valid/ready handshake. It is the array-level building block for output-stationary and multi-lane dataflows.

## Interface

- DATA_W, 8, width of each activation/weight element
- LANES, 4, elements per beat
- ACC_W, 32, accumulator/partial-sum width; must be ≥ 2*DATA_W+$clog2(LANES)+1
- SEM, 1, 1 = sign-magnitude inputs (MSB sign), 0 = two's complement
- CNT_W, 8, width of beat-count field
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- w_load  in  1  load weight vector (honoured only in IDLE)
- w_in  in  LANES*DATA_W  weights; lane i at [i*DATA_W +: DATA_W]
- start  in  1  begin an accumulation job (honoured only in IDLE)
- len  in  CNT_W  number of activation beats in the job; sampled with start
- psum_in  in  ACC_W  initial partial sum, two's complement; sampled with start
- act_valid  in  1  activation beat valid
- act_in  in  LANES*DATA_W  activations, same lane packing as w_in
- act_ready  out  1  beat accepted when act_valid && act_ready
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_psum  out  ACC_W  accumulated result, two's complement
- sat  out  1  result saturated during this job (valid with out_valid)

## Operation

- FSM states: IDLE, ACCUM, FLUSH, DONE.
- IDLE: act_ready=0, out_valid=0.
  - w_load=1 registers w_in.
  - start=1 loads acc←psum_in, cnt←len, sat←0, and moves to ACCUM (FLUSH if len=0).
  - If w_load and start are high together, the new weights apply to this job.
- ACCUM: act_ready=1. Each accepted beat registers the lane-reduced product sum into the product stage and decrements cnt. The accepted beat that brings cnt to 0 moves the FSM to FLUSH.
- Product stage: a valid product stage is added into acc on the next edge, regardless of state.
- FLUSH: act_ready=0. The final product is added. Go to DONE.
- DONE: out_valid=1 and out_psum=acc. On out_ready=1, return to IDLE. In DONE, start and w_load are ignored.
- SEM=1 arithmetic:
  - element = (-1)^MSB × magnitude[DATA_W-2:0].
  - Product sign = XOR of the two signs; magnitude = product of the two magnitudes.
  - The product is converted to two's complement; negative zero gives 0.
- SEM=0 arithmetic: signed × signed, full 2*DATA_W-bit product.
- Lane products are summed at full width, sign-extended to ACC_W, then added to acc.
- Saturation:
  - Signed overflow on the acc add clamps acc to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - sat is set and stays set until the next start.
  - Accumulation continues from the clamped value.
- len is not re-sampled mid-job. Beats presented outside ACCUM are not consumed.

## Timing

- Reset values: state=IDLE, weights=0, acc=0, cnt=0, product stage invalid.
  - Outputs: act_ready=0, out_valid=0, out_psum=0, sat=0.
- Reset is asynchronous. Asserting it mid-job aborts the job immediately, with no output produced.
- Latency with no stalls: start is sampled on edge E. act_ready is high from E+1. out_valid rises after edge E+len+1.
- Throughput: one beat per cycle while in ACCUM. An act_valid gap of g cycles adds g cycles of latency.
- out_psum and sat are stable while out_valid=1 && out_ready=0.
- Back-to-back jobs: IDLE is entered on the edge after the out_ready handshake. The earliest next start is sampled on that IDLE cycle. Minimum job period is len+3 cycles.
- w_in is captured only on an edge where state=IDLE and w_load=1.

## Test plan

- Reset: assert rst_n=0 mid-ACCUM -> same cycle, act_ready=0, out_valid=0, out_psum=0, sat=0; after release, state is IDLE.
- SEM=1 single beat:
  - Stimulus: w={0x83,0x05,0x00,0x80}, act={0x02,0x84,0x7F,0x7F}, psum_in=10, len=1.
  - Response: products -6, -20, 0, 0 -> out_psum=0xFFFFFFF0 (-16), sat=0; out_valid after edge E+2.
- Stalled stream:
  - Stimulus: len=3, act={1,2,3,4}, w={1,1,1,1}, psum_in=0, act_valid low for 2 cycles between beats.
  - Response: out_psum=30; out_valid after edge E+8; exactly 3 beats consumed.
- Saturation:
  - Stimulus: SEM=1, w=act={0x7F×4}, psum_in=0x7FFFFFF0, len=2.
  - Response: out_psum=0x7FFFFFFF, sat=1. The next job, with psum_in=0, len=1 and the same w/act, gives out_psum=64516 (4×127×127), sat=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing start and w_load -> out_valid stays 1, out_psum unchanged, weights unchanged, no new job starts.
- len=0, psum_in=-7 -> out_psum=0xFFFFFFF9 after edge E+1, act_ready never asserted; repeat with SEM=0, w={-1,…}, act={-128,…}, len=1, psum_in=0 -> out_psum=512.
